// File: rtl/otter_pkg.sv
// Shared Otter types for the fetch stage: widths, the NOP encoding, fetch FSM states and
// the decode-queue entry layout.
package otter_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, KILL} fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_if.sv
// Fetch-stage bundle: PC register load, instruction-memory req/ack and the decode handshake.
// if_misaligned exists only when OTTER_FETCH_MISALIGN_EN is defined.
interface otter_fetch_if;
    import otter_pkg::*;

    logic [XLEN-1:0] pc;
    logic            pc_ld;
    logic [XLEN-1:0] pc_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_addr;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
`ifdef OTTER_FETCH_MISALIGN_EN
    logic            if_misaligned;
`endif

    modport master (
        input  pc,
        output pc_ld,
        output pc_data,
        input  redirect,
        input  redirect_addr,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
`ifdef OTTER_FETCH_MISALIGN_EN
        , output if_misaligned
`endif
    );

    modport slave (
        output pc,
        input  pc_ld,
        input  pc_data,
        output redirect,
        output redirect_addr,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
`ifdef OTTER_FETCH_MISALIGN_EN
        , input if_misaligned
`endif
    );

endinterface

// File: rtl/otter_fetch_buf.sv
// Two-entry fetch queue; slot 0 is always the head. Flush beats push and pop, and both reset
// and flush zero the stored entries.
module otter_fetch_buf
    import otter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_count  <= 2'd0;
        end else begin
            unique case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem[0] <= i_entry;
                    else                 r_mem[1] <= i_entry;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem[0] <= r_mem[1];
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem[0] <= i_entry;
                    end else begin
                        r_mem[0] <= r_mem[1];
                        r_mem[1] <= i_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[0];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/otter_fetch.sv
// Otter instruction-fetch stage: one imem read outstanding, drives the PC register, queues
// fetched words toward decode. OTTER_FETCH_MISALIGN_EN enables misaligned-fetch markers.
module otter_fetch
    import otter_pkg::*;
(
    input logic           clk,
    input logic           rst,
    otter_fetch_if.master bus
);

    fetch_state_t    r_state, w_state_next;
    logic [XLEN-1:0] r_req_pc;
    logic            r_block;

    logic            w_misalign, w_can_issue, w_issue, w_ack_ok, w_mis_push;
    logic            w_imem_req, w_pc_ld, w_push, w_pop, w_head_valid;
    logic [XLEN-1:0] w_pc_data;
    logic [1:0]      w_count;
    fetch_entry_t    w_push_entry, w_head;

`ifdef OTTER_FETCH_MISALIGN_EN
    assign w_misalign = (bus.pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_can_issue = (r_state == IDLE) && (w_count < 2'd2) && !bus.redirect && !r_block;
    assign w_issue     = w_can_issue && !w_misalign;
    assign w_mis_push  = w_can_issue && w_misalign;
    assign w_ack_ok    = (r_state == WAIT) && bus.imem_ack && !bus.redirect;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_issue) w_state_next = WAIT;
            WAIT: begin
                if (bus.imem_ack)     w_state_next = IDLE;
                else if (bus.redirect) w_state_next = KILL;
            end
            KILL: if (bus.imem_ack) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The block flag only ever sets in the misaligned build; a redirect always clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc <= '0;
            r_block  <= 1'b0;
        end else begin
            if (w_issue) r_req_pc <= bus.pc;
            if (bus.redirect)    r_block <= 1'b0;
            else if (w_mis_push) r_block <= 1'b1;
        end
    end

    always_comb begin
        w_imem_req   = 1'b0;
        w_pc_ld      = 1'b0;
        w_pc_data    = '0;
        w_push       = 1'b0;
        w_push_entry = '0;
        if (!rst) begin
            w_imem_req = (r_state == WAIT) || (r_state == KILL);
            if (bus.redirect) begin
                w_pc_ld   = 1'b1;
                w_pc_data = bus.redirect_addr;
            end else if (w_ack_ok) begin
                w_pc_ld   = 1'b1;
                w_pc_data = r_req_pc + XLEN'(4);
            end
            if (w_ack_ok) begin
                w_push       = 1'b1;
                w_push_entry = '{pc: r_req_pc, instr: bus.imem_rdata, misaligned: 1'b0};
            end else if (w_mis_push) begin
                w_push       = 1'b1;
                w_push_entry = '{pc: bus.pc, instr: NOP_INSTR, misaligned: 1'b1};
            end
        end
    end

    assign w_pop = w_head_valid && bus.if_ready;

    otter_fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .o_head  (w_head),
        .o_valid (w_head_valid),
        .o_count (w_count)
    );

    assign bus.imem_req  = w_imem_req;
    assign bus.imem_addr = {r_req_pc[XLEN-1:2], 2'b00};
    assign bus.pc_ld     = w_pc_ld;
    assign bus.pc_data   = w_pc_data;
    assign bus.if_valid  = w_head_valid;
    assign bus.if_instr  = w_head.instr;
    assign bus.if_pc     = w_head.pc;
`ifdef OTTER_FETCH_MISALIGN_EN
    assign bus.if_misaligned = w_head.misaligned;
`else
    logic w_unused_misaligned;
    assign w_unused_misaligned = w_head.misaligned;
`endif

endmodule

// File: doc/otter_fetch.md
# otter_fetch

Instruction-fetch stage for the Otter RISC-V core, directly downstream of the PC register. Each cycle it reads the current PC and issues an instruction-memory read over a req/ack handshake. It drives the PC register's `ld`/`data` inputs with PC+4 or a redirect target, and buffers fetched instructions in a 2-entry queue toward decode using valid/ready.

## Interface
- `XLEN`, 32, address/instruction width
- `NOP_INSTR`, 32'h0000_0013, instruction word presented on a misaligned fetch (macro only)

- `clk` in 1: sole clock; all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `pc` in XLEN: current PC register value
- `pc_ld` out 1: load strobe to the PC register
- `pc_data` out XLEN: next PC value, valid when `pc_ld`=1
- `redirect` in 1: branch/jump/trap redirect from execute
- `redirect_addr` in XLEN: redirect target
- `imem_req` out 1: memory read request, held until ack
- `imem_addr` out XLEN: read address, stable while `imem_req`=1
- `imem_ack` in 1: read complete; `imem_rdata` valid this cycle
- `imem_rdata` in XLEN: instruction word
- `if_valid` out 1: buffer head valid toward decode
- `if_ready` in 1: decode accepts head
- `if_instr` out XLEN: head instruction
- `if_pc` out XLEN: PC of head instruction
- `if_misaligned` out 1: head is a misaligned-fetch marker (exists only with the macro)

## Operation
- FSM states: IDLE, WAIT, KILL. At most one request outstanding.
- IDLE → WAIT: buffer count < 2 and `redirect`=0. Latch `pc` into `req_pc`. Assert `imem_req` with `imem_addr`=`req_pc` from the next cycle.
- WAIT, `imem_ack`=1, no redirect:
  - Push {`req_pc`, `imem_rdata`} into the buffer.
  - `pc_ld`=1, `pc_data`=`req_pc`+4 (mod 2^XLEN; wraps 32'hFFFF_FFFC→0).
  - Return to IDLE.
- Redirect (any state):
  - Same cycle: `pc_ld`=1, `pc_data`=`redirect_addr`. Redirect has priority over the PC+4 update.
  - Buffer flushed at the clock edge. A same-cycle pop is discarded.
  - WAIT with no ack → KILL. WAIT with ack → data dropped, go to IDLE. IDLE stays IDLE (no issue this cycle).
- KILL: keep `imem_req` high until ack, discard the response, then go to IDLE. A redirect in KILL reloads the PC and stays in KILL.
- Buffer: head drives `if_*`. Pop on `if_valid && if_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - A push never meets a full buffer, because issue requires count < 2.
- Reset (takes effect mid-transaction too):
  - State IDLE, buffer empty.
  - `pc_ld`, `imem_req`, `if_valid`, `if_misaligned` = 0.
  - `pc_data`, `imem_addr`, `if_instr`, `if_pc` = 0.
  - Instruction memory must tolerate a request abandoned by reset.

## Timing
- Issue-to-request latency is 1 cycle. Earliest ack is the first WAIT cycle.
- With zero-wait memory, throughput is one instruction per 2 cycles.
- A pushed entry is visible on `if_valid` the cycle after the ack.
- `pc_ld` is a single-cycle pulse. The PC register shows the new value the following cycle, in time for the next IDLE issue.
- `imem_addr` must not change while `imem_req`=1.

## Configuration
- `OTTER_FETCH_MISALIGN_EN` defined:
  - At issue, if `pc[1:0]`≠0, no memory request is made.
  - Push {`pc`, `NOP_INSTR`, `if_misaligned`=1} and set a sticky block flag.
  - No further issue or `pc_ld` until a redirect clears the flag.
- Undefined:
  - `imem_addr`={`req_pc`[31:2],2'b00}. `pc[1:0]` is ignored for addressing but carried in `if_pc`.
  - `if_misaligned` port is absent.

## Structure
- Shared package `otter_pkg`:
  - `XLEN`, `NOP_INSTR`.
  - `fetch_state_t` enum {IDLE, WAIT, KILL}.
  - `fetch_entry_t` struct {pc, instr, misaligned}.
- Sub-module `otter_fetch_buf`: 2-entry FIFO of `fetch_entry_t` with push, pop, flush, count, and sync reset. Flush has priority over push and pop.

## Test plan
- Reset, `pc`=0, `imem_ack` tied high:
  - `imem_req` rises with `imem_addr`=0.
  - `pc_ld` pulses with `pc_data`=4.
  - Instructions at `if_pc` 0, 4, 8 appear every 2 cycles.
- `if_ready`=0 with zero-wait memory: exactly 2 entries buffered, then `imem_req` stays low. Raising `if_ready` drains the entries in order and fetch resumes.
- Redirect to 32'h100 while in WAIT with ack delayed 3 cycles:
  - `pc_ld` with `pc_data`=32'h100 in the redirect cycle.
  - The late response is discarded (KILL).
  - The next `if_pc` is 32'h100.
- Redirect in the same cycle as an ack and a pop: buffer empties, data dropped, `if_valid`=0 the next cycle.
- `pc`=32'hFFFF_FFFC fetch → `pc_data`=0.
- With the macro, redirect to 32'h102:
  - No `imem_req`.
  - Entry with `if_misaligned`=1, `if_instr`=32'h13, `if_pc`=32'h102.
  - Fetch stalls until a redirect to 32'h200.
- `rst` asserted while in WAIT: next cycle `imem_req`=0, `if_valid`=0, state IDLE.
